// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// A circular register array with wrap-by-compare pointers and an occupancy counter.
//
// Parameters:
//   data_depth : MSB index of the data word (word width is data_depth+1)
//   mem_depth  : number of entries, any value >= 2
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   w_data : write data, stored when a write is accepted
//   wq     : write request (one word per cycle while high)
//   rq     : read request (one word per cycle while high)
//   r_data : registered read data, holds between reads
//   full   : occupancy equals mem_depth
//   empty  : occupancy is zero
module fifo #(
    parameter int unsigned data_depth = 7,
    parameter int unsigned mem_depth  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_depth:0]   w_data,
    input  logic                  wq,
    input  logic                  rq,
    output logic [data_depth:0]   r_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DW = data_depth + 1;
    localparam int unsigned PW = $clog2(mem_depth);
    localparam int unsigned CW = $clog2(mem_depth + 1);

    logic [DW-1:0] mem [mem_depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;

    // Flags decode straight from the registered count.
    assign full  = (count == CW'(mem_depth));
    assign empty = (count == '0);

    // A write into a full FIFO is allowed only when a read frees the head slot in the same cycle.
    assign wr_en = wq && (!full || rq);
    assign rd_en = rq && !empty;

    // Explicit wrap so non-power-of-two depths work.
    assign wr_ptr_nxt = (wr_ptr == PW'(mem_depth - 1)) ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_nxt = (rd_ptr == PW'(mem_depth - 1)) ? '0 : rd_ptr + PW'(1);

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= w_data;
        end
    end

    // Pointers, occupancy and read data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            r_data <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr_nxt;
                r_data <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo (data_depth=7, mem_depth=6).
// A queue model holds the expected contents; words are pushed when a write is driven
// and popped/compared when the DUT returns read data.
module tb_fifo;

    localparam int unsigned DEPTH = 6;

    logic       clk;
    logic       rst;
    logic [7:0] w_data;
    logic       wq;
    logic       rq;
    logic [7:0] r_data;
    logic       full;
    logic       empty;

    fifo #(
        .data_depth (7),
        .mem_depth  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .w_data (w_data),
        .wq     (wq),
        .rq     (rq),
        .r_data (r_data),
        .full   (full),
        .empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sb_q[$];
    logic [7:0] exp_r;
    int unsigned n_checks;
    int unsigned n_pass;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of stimulus; the model decides acceptance from its own occupancy.
    task automatic cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
        bit m_full;
        bit m_empty;
        bit acc_w;
        bit acc_r;
        m_full  = (sb_q.size() == DEPTH);
        m_empty = (sb_q.size() == 0);
        acc_w   = w && (!m_full || r);
        acc_r   = r && !m_empty;
        wq      = w;
        rq      = r;
        w_data  = d;
        @(posedge clk);
        #1;
        if (acc_r) exp_r = sb_q.pop_front();
        if (acc_w) sb_q.push_back(d);
        wq = 1'b0;
        rq = 1'b0;
        check({tag, "_rdata"}, r_data, exp_r);
        check({tag, "_empty"}, empty, (sb_q.size() == 0) ? 1 : 0);
        check({tag, "_full"},  full,  (sb_q.size() == DEPTH) ? 1 : 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_r    = 8'd0;
        wq       = 1'b0;
        rq       = 1'b0;
        w_data   = 8'd0;
        rst      = 1'b0;

        // Reset held for 30 time units.
        #30;
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_rdata", r_data, 0);
        #2 rst = 1'b1;

        // Basic order and underflow.
        cycle("push1", 1'b1, 1'b0, 8'd1);
        cycle("push2", 1'b1, 1'b0, 8'd2);
        cycle("pop1",  1'b0, 1'b1, 8'd0);
        check("pop1_val", r_data, 1);
        cycle("pop2",  1'b0, 1'b1, 8'd0);
        check("pop2_val", r_data, 2);
        cycle("pop_empty", 1'b0, 1'b1, 8'd0);
        check("pop_empty_hold", r_data, 2);

        // Asynchronous reset mid-fill.
        cycle("mf_push", 1'b1, 1'b0, 8'd33);
        cycle("mf_push", 1'b1, 1'b0, 8'd34);
        cycle("mf_pop",  1'b0, 1'b1, 8'd0);
        #2 rst = 1'b0;
        #1;
        check("mrst_empty", empty, 1);
        check("mrst_full",  full,  0);
        check("mrst_rdata", r_data, 0);
        sb_q.delete();
        exp_r = 8'd0;
        #1 rst = 1'b1;

        // Fill, overflow, drain.
        for (int i = 1; i <= 6; i++) cycle("fill", 1'b1, 1'b0, 8'(i * 10));
        check("fill_full", full, 1);
        for (int i = 7; i <= 13; i++) cycle("ovf", 1'b1, 1'b0, 8'(i * 10));
        check("ovf_full", full, 1);
        for (int i = 1; i <= 6; i++) begin
            cycle("drain", 1'b0, 1'b1, 8'd0);
            check("drain_val", r_data, i * 10);
        end
        check("drain_empty", empty, 1);

        // Wrap-around: pop one, push it back, many times.
        cycle("wr_pre", 1'b1, 1'b0, 8'd7);
        cycle("wr_pre", 1'b1, 1'b0, 8'd8);
        cycle("wr_pre", 1'b1, 1'b0, 8'd9);
        for (int i = 0; i < 15; i++) begin
            cycle("wrap_pop",  1'b0, 1'b1, 8'd0);
            cycle("wrap_push", 1'b1, 1'b0, exp_r);
        end
        for (int i = 0; i < 3; i++) cycle("wrap_drain", 1'b0, 1'b1, 8'd0);
        check("wrap_last", r_data, 9);
        check("wrap_empty", empty, 1);

        // Simultaneous read/write at full.
        for (int i = 1; i <= 6; i++) cycle("sf_fill", 1'b1, 1'b0, 8'(i * 10));
        cycle("sim_full", 1'b1, 1'b1, 8'd140);
        check("sim_full_val", r_data, 10);
        check("sim_full_flag", full, 1);
        for (int i = 0; i < 6; i++) cycle("sf_drain", 1'b0, 1'b1, 8'd0);
        check("sf_last", r_data, 140);

        // Simultaneous read/write at empty.
        cycle("sim_empty", 1'b1, 1'b1, 8'd5);
        check("sim_empty_hold", r_data, 140);
        check("sim_empty_flag", empty, 0);
        cycle("se_pop", 1'b0, 1'b1, 8'd0);
        check("se_pop_val", r_data, 5);
        check("se_pop_empty", empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
